// File: rtl/wbuart_init_seq.sv
// Boot-time wbuart32 setup sequencer: writes the setup word, then hands the bus to the core.
// Define WBUART_INIT_VERIFY_EN to add a read-back check of the written setup word.
`timescale 1ns/1ps
module wbuart_init_seq #(
    parameter logic [31:0] SETUP_ADDR     = 32'hA000_0020,
    parameter logic [31:0] SETUP_VALUE    = 32'h8000_02B6,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        core_cyc_i,
    input  logic        core_stb_i,
    input  logic        core_we_i,
    input  logic [31:0] core_adr_i,
    input  logic [31:0] core_dat_i,
    input  logic [3:0]  core_sel_i,
    output logic        core_stall_o,
    output logic        core_ack_o,
    output logic [31:0] core_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        init_done_o,
    output logic        init_err_o
);

    typedef enum logic [2:0] {
        START,
        WR_REQ,
        WR_WAIT,
`ifdef WBUART_INIT_VERIFY_EN
        RD_REQ,
        RD_WAIT,
`endif
        DONE,
        FAIL
    } state_e;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] tmo_inc;
    logic [7:0]  retry_q, retry_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        pass;
    logic        fail;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_inc = tmo_q + 16'd1;
        pass    = 1'b0;
        fail    = 1'b0;

        unique case (state_q)
            START: state_d = WR_REQ;
            // First cycle in a request state has cyc low: it is the bus gap.
            WR_REQ: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = SETUP_ADDR;
                    dat_d = SETUP_VALUE;
                    sel_d = 4'hF;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
`ifdef WBUART_INIT_VERIFY_EN
                    state_d = RD_REQ;
`else
                    pass = 1'b1;
`endif
                end else if (tmo_inc == TMO_LIMIT) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
`ifdef WBUART_INIT_VERIFY_EN
            RD_REQ: begin
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = SETUP_ADDR;
                    sel_d = 4'hF;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (wb_dat_i == SETUP_VALUE) begin
                        pass = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_inc == TMO_LIMIT) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
`endif
            default: ;
        endcase

        if (pass) begin
            state_d = DONE;
            done_d  = 1'b1;
        end

        // Retry re-enters WR_REQ with cyc low, giving the idle cycle.
        if (fail) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 8'd1;
                state_d = WR_REQ;
            end else begin
                state_d = FAIL;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= START;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        if (done_q) begin
            wb_cyc_o     = core_cyc_i;
            wb_stb_o     = core_stb_i;
            wb_we_o      = core_we_i;
            wb_adr_o     = core_adr_i;
            wb_dat_o     = core_dat_i;
            wb_sel_o     = core_sel_i;
            core_stall_o = wb_stall_i;
            core_ack_o   = wb_ack_i;
            core_dat_o   = wb_dat_i;
        end else begin
            wb_cyc_o     = cyc_q;
            wb_stb_o     = stb_q;
            wb_we_o      = we_q;
            wb_adr_o     = adr_q;
            wb_dat_o     = dat_q;
            wb_sel_o     = sel_q;
            core_stall_o = 1'b1;
            core_ack_o   = 1'b0;
            core_dat_o   = '0;
        end
    end

    assign init_done_o = done_q;
    assign init_err_o  = err_q;

endmodule

// File: tb/tb_wbuart_init_seq.sv
// Bench for wbuart_init_seq: timeline model of the boot sequence, random slave plans,
// plus a table of hand-written pass-through vectors.
`timescale 1ns/1ps
module tb_wbuart_init_seq;

    localparam logic [31:0] SA = 32'hA000_0020;
    localparam logic [31:0] SV = 32'h8000_02B6;
    localparam int T    = 8;
    localparam int MR   = 3;
    localparam int MAXC = 512;
`ifdef WBUART_INIT_VERIFY_EN
    localparam int PH = 2;
`else
    localparam int PH = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        core_cyc_i, core_stb_i, core_we_i;
    logic [31:0] core_adr_i, core_dat_i;
    logic [3:0]  core_sel_i;
    logic        core_stall_o, core_ack_o;
    logic [31:0] core_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i, wb_ack_i;
    logic [31:0] wb_dat_i;
    logic        init_done_o, init_err_o;

    wbuart_init_seq #(
        .SETUP_ADDR(SA), .SETUP_VALUE(SV),
        .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .core_cyc_i(core_cyc_i), .core_stb_i(core_stb_i), .core_we_i(core_we_i),
        .core_adr_i(core_adr_i), .core_dat_i(core_dat_i), .core_sel_i(core_sel_i),
        .core_stall_o(core_stall_o), .core_ack_o(core_ack_o), .core_dat_o(core_dat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .init_done_o(init_done_o), .init_err_o(init_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        cyc, stb, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        done, err, cstall, cack;
        logic [31:0] cdat;
    } obs_t;

    // Slave behaviour per request: stall cycles, ack delay after accept (0 = never), read data.
    typedef struct {
        int          stall;
        int          ack;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic        ccyc, cstb, cwe;
        logic [31:0] cadr, cdat;
        logic [3:0]  csel;
        logic        wstall, wack;
        logic [31:0] wdat;
        obs_t        exp;
    } tv_t;

    plan_t plans[16];
    tv_t   tv[4];
    bit    e_cyc[MAXC];
    bit    e_stb[MAXC];
    bit    e_we[MAXC];
    int    e_done;
    bit    e_err;
    int    vecs = 0;
    int    bad  = 0;

    // Paints the expected bus timeline from the plan list: each request starts
    // with stb at s, is accepted at s+stall, and ends at its ack or after T wait cycles.
    task automatic model();
        int s, a, e, k;
        bit good, ok;
        for (int i = 0; i < MAXC; i++) begin
            e_cyc[i] = 0;
            e_stb[i] = 0;
            e_we[i]  = 0;
        end
        s = 2; k = 0; e = 0; e_done = 0; e_err = 0;
        for (int att = 0; att <= MR; att++) begin
            ok = 1;
            for (int ph = 0; ph < PH; ph++) begin
                a = s + plans[k].stall;
                if (plans[k].ack >= 1 && plans[k].ack <= T) begin
                    e = a + plans[k].ack;
                    good = (ph == 0) || (plans[k].rdata == SV);
                end else begin
                    e = a + T;
                    good = 0;
                end
                for (int c = s; c <= e; c++) begin
                    e_cyc[c] = 1;
                    e_stb[c] = (c <= a);
                    e_we[c]  = (ph == 0);
                end
                k++;
                s = e + 2;
                if (!good) begin
                    ok = 0;
                    break;
                end
            end
            if (ok || att == MR) begin
                e_done = e + 1;
                e_err  = !ok;
                break;
            end
        end
    endtask

    task automatic set_plans(input int st, input int ak, input logic [31:0] rd);
        for (int i = 0; i < 16; i++) begin
            plans[i].stall = st;
            plans[i].ack   = ak;
            plans[i].rdata = rd;
        end
    endtask

    task automatic rand_plans();
        int r;
        for (int i = 0; i < 16; i++) begin
            plans[i].stall = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            plans[i].ack = (r < 2) ? 0 : (r < 3) ? T + 1 : $urandom_range(1, T);
            plans[i].rdata = ($urandom_range(0, 3) == 0) ? $urandom : SV;
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
             init_done_o, init_err_o, core_stall_o, core_ack_o, core_dat_o};
        return o;
    endfunction

    task automatic compare(input string nm, input obs_t got, input obs_t exp, input obs_t msk);
        vecs++;
        if (((got ^ exp) & msk) !== '0) begin
            bad++;
            $display("FAIL %s: actual %h required %h", nm, got & msk, exp & msk);
        end
    endtask

    task automatic drive_core(input bit busy);
        core_cyc_i = busy ? 1'b1 : 1'($urandom_range(0, 1));
        core_stb_i = busy ? 1'b1 : 1'($urandom_range(0, 1));
        core_we_i  = 1'($urandom_range(0, 1));
        core_adr_i = $urandom;
        core_dat_i = $urandom;
        core_sel_i = 4'($urandom_range(0, 15));
    endtask

    task automatic run_scn(input int id, input int ncyc, input bit busy);
        plan_t cur;
        int    k, srem, ack_at;
        bit    pstb, stb;
        obs_t  exp, msk;
        cur = plans[0]; k = 0; srem = 0; ack_at = -1; pstb = 0;
        rstn_i = 1'b0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            drive_core(busy);
            #1;
            exp = '0;
            exp.cstall = 1'b1;
            compare($sformatf("scn%0d reset%0d", id, r), sample(), exp, '1);
        end
        rstn_i = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk_i);
            drive_core(busy && c <= e_done);
            if (c < e_done) begin
                stb = wb_stb_o;
                if (stb && !pstb) begin
                    if (k < 16) cur = plans[k];
                    else begin
                        cur.stall = 0; cur.ack = 1; cur.rdata = SV;
                    end
                    k++;
                    srem = cur.stall;
                end
                if (stb) begin
                    wb_stall_i = (srem > 0);
                    if (srem > 0) srem--;
                    else ack_at = (cur.ack > 0) ? c + cur.ack : -1;
                end else begin
                    wb_stall_i = 1'($urandom_range(0, 1));
                end
                wb_ack_i = (c == ack_at);
                wb_dat_i = wb_ack_i ? cur.rdata : $urandom;
                pstb = stb;
            end else begin
                wb_stall_i = 1'($urandom_range(0, 1));
                wb_ack_i   = 1'($urandom_range(0, 1));
                wb_dat_i   = $urandom;
            end
            #1;
            exp = '0;
            msk = '1;
            if (c < e_done) begin
                exp.cyc = e_cyc[c];
                exp.stb = e_stb[c];
                exp.we  = e_we[c];
                exp.adr = SA;
                exp.dat = SV;
                exp.sel = 4'hF;
                exp.cstall = 1'b1;
                if (!e_stb[c]) begin
                    msk.we = 0; msk.adr = '0; msk.dat = '0; msk.sel = '0;
                end else if (!e_we[c]) begin
                    msk.dat = '0;
                end
            end else begin
                exp = {core_cyc_i, core_stb_i, core_we_i, core_adr_i, core_dat_i,
                       core_sel_i, 1'b1, e_err, wb_stall_i, wb_ack_i, wb_dat_i};
            end
            compare($sformatf("scn%0d cyc%0d", id, c), sample(), exp, msk);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            core_cyc_i = tv[i].ccyc;
            core_stb_i = tv[i].cstb;
            core_we_i  = tv[i].cwe;
            core_adr_i = tv[i].cadr;
            core_dat_i = tv[i].cdat;
            core_sel_i = tv[i].csel;
            wb_stall_i = tv[i].wstall;
            wb_ack_i   = tv[i].wack;
            wb_dat_i   = tv[i].wdat;
            #1;
            compare($sformatf("table%0d", i), sample(), tv[i].exp, '1);
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        drive_core(1'b0);
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;

        tv[0] = '{1'b1, 1'b1, 1'b0, SA, 32'h0, 4'hF, 1'b0, 1'b1, SV,
                  {1'b1, 1'b1, 1'b0, SA, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, SV}};
        tv[1] = '{1'b1, 1'b1, 1'b1, 32'hA000_0024, 32'h55, 4'h3, 1'b1, 1'b0, 32'h0,
                  {1'b1, 1'b1, 1'b1, 32'hA000_0024, 32'h55, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0}};
        tv[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF,
                  {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF}};
        tv[3] = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 4'h8, 1'b1, 1'b1, 32'h0F0F_0F0F,
                  {1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0F0F_0F0F}};

        // Nominal sequence with the core requesting from the start, then pass-through table.
        set_plans(0, 1, SV);
        model();
        run_scn(0, e_done + 6, 1'b1);
        run_table();

        // Long stall on the first request.
        set_plans(0, 1, SV);
        plans[0].stall = 10;
        model();
        run_scn(1, e_done + 4, 1'b0);

        // Slave never acks: all retries time out.
        set_plans(0, 0, SV);
        model();
        run_scn(2, e_done + 4, 1'b0);

        // Ack one cycle too late lands in the idle cycle and is ignored.
        set_plans(1, 1, SV);
        plans[0].ack = T + 1;
        model();
        run_scn(3, e_done + 4, 1'b0);

`ifdef WBUART_INIT_VERIFY_EN
        // First read-back returns zero, second is correct.
        set_plans(0, 1, SV);
        plans[1].rdata = 32'h0;
        model();
        run_scn(4, e_done + 4, 1'b0);
`endif

        // Reset pulsed while waiting for the write ack, then a clean restart.
        set_plans(0, 0, SV);
        model();
        run_scn(5, 5, 1'b0);
        set_plans(0, 1, SV);
        model();
        run_scn(6, e_done + 4, 1'b0);

        for (int n = 0; n < 30; n++) begin
            rand_plans();
            model();
            run_scn(10 + n, e_done + 4, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
